// File: rtl/dram_pkg.sv
// Shared types and elaboration-time checks for the dual-port distributed-RAM bank.
package dram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned MIN_DEPTH = 32;
  localparam int unsigned MAX_DEPTH = 128;

  // Legal depths are exactly the powers of two between MIN_DEPTH and MAX_DEPTH.
  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dram_clear_seq.sv
// Clear sequencer: walks every address once, one write per cycle, then returns to IDLE.
module dram_clear_seq
  import dram_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] addr
);

  localparam int AW = $clog2(DEPTH);

  clr_state_e    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clr) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        // clr is deliberately not looked at here: a request mid-sequence must not restart it.
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign addr = cnt;

endmodule

// File: rtl/dram_dp_bank.sv
// Dual-port LUT-RAM bank: one write/SPO port, one DPO read port, with a hardware clear sequencer.
module dram_dp_bank
  import dram_pkg::*;
#(
  parameter int               WIDTH   = 2,
  parameter int               DEPTH   = 32,
  parameter int               OUT_REG = 0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     clr,
  output logic [WIDTH-1:0]         spo,
  output logic [WIDTH-1:0]         dpo,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("dram_dp_bank: DEPTH=%0d is not one of 32, 64, 128", DEPTH);
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("dram_dp_bank: WIDTH=%0d is outside 1..32", WIDTH);
  end

  logic [AW-1:0]    clr_addr;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  dram_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .busy  (busy),
    .addr  (clr_addr)
  );

  // The sequencer owns the write port while busy; a clr in IDLE drops the coincident user write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = wdata;
    if (busy) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = CLR_VAL;
    end else if (we && !clr) begin
      mem_we = 1'b1;
    end
  end

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; a reset branch would turn the LUT RAM into a bank of flops.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  if (OUT_REG != 0) begin : g_out_reg
    // Registering the asynchronous LUT read gives read-first behaviour on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        spo <= '0;
        dpo <= '0;
      end else begin
        spo <= mem[waddr];
        dpo <= mem[raddr];
      end
    end
  end else begin : g_out_comb
    assign spo = mem[waddr];
    assign dpo = mem[raddr];
  end

endmodule

// File: tb/tb_dram_dp_bank.sv
// Randomised and directed bench for dram_dp_bank across both output modes and three depths.
module tb_dram_dp_bank;

  localparam logic [7:0] CLR_AB = 8'h3C;
  localparam logic [1:0] CLR_CD = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // a/b: WIDTH=8 DEPTH=128, async vs registered outputs, sharing one stimulus bus.
  logic       ab_we, ab_clr;
  logic [6:0] ab_waddr, ab_raddr;
  logic [7:0] ab_wdata;
  logic [7:0] spo_a, dpo_a, spo_b, dpo_b;
  logic       busy_a, busy_b;

  // c: WIDTH=2 DEPTH=32 async outputs; d: WIDTH=2 DEPTH=64 registered outputs.
  logic       cd_we, cd_clr;
  logic [5:0] cd_waddr, cd_raddr;
  logic [1:0] cd_wdata;
  logic [1:0] spo_c, dpo_c, spo_d, dpo_d;
  logic       busy_c, busy_d;

  int checks = 0;
  int errors = 0;

  dram_dp_bank #(.WIDTH(8), .DEPTH(128), .OUT_REG(0), .CLR_VAL(CLR_AB)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(ab_we), .waddr(ab_waddr), .wdata(ab_wdata),
    .raddr(ab_raddr), .clr(ab_clr), .spo(spo_a), .dpo(dpo_a), .busy(busy_a));

  dram_dp_bank #(.WIDTH(8), .DEPTH(128), .OUT_REG(1), .CLR_VAL(CLR_AB)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(ab_we), .waddr(ab_waddr), .wdata(ab_wdata),
    .raddr(ab_raddr), .clr(ab_clr), .spo(spo_b), .dpo(dpo_b), .busy(busy_b));

  dram_dp_bank #(.WIDTH(2), .DEPTH(32), .OUT_REG(0), .CLR_VAL(CLR_CD)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(cd_we), .waddr(cd_waddr[4:0]), .wdata(cd_wdata),
    .raddr(cd_raddr[4:0]), .clr(cd_clr), .spo(spo_c), .dpo(dpo_c), .busy(busy_c));

  dram_dp_bank #(.WIDTH(2), .DEPTH(64), .OUT_REG(1), .CLR_VAL(CLR_CD)) dut_d (
    .clk(clk), .rst_n(rst_n), .we(cd_we), .waddr(cd_waddr), .wdata(cd_wdata),
    .raddr(cd_raddr), .clr(cd_clr), .spo(spo_d), .dpo(dpo_d), .busy(busy_d));

  // Reference model for a/b: an array plus a count of clear writes still owed.
  logic [7:0] mdl [128];
  int         clr_left = 0;
  int         clr_ptr  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left = 0;
      clr_ptr  = 0;
    end else if (clr_left > 0) begin
      mdl[clr_ptr] = CLR_AB;
      clr_ptr++;
      clr_left--;
    end else if (ab_clr) begin
      clr_left = 128;
      clr_ptr  = 0;
    end else if (ab_we) begin
      mdl[ab_waddr] = ab_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ab_we = 0; ab_clr = 0; ab_waddr = '0; ab_raddr = '0; ab_wdata = '0;
    cd_we = 0; cd_clr = 0; cd_waddr = '0; cd_raddr = '0; cd_wdata = '0;
    foreach (mdl[i]) mdl[i] = 'x;
    #12;
    checks++;
    if ({busy_a, busy_b, busy_c, busy_d} !== 4'b0000) begin
      errors++; $display("FAIL reset_busy got %b exp 0000", {busy_a, busy_b, busy_c, busy_d});
    end
    checks++;
    if ({spo_b, dpo_b} !== 16'h0000) begin
      errors++; $display("FAIL reset_regs_b got %h exp 0000", {spo_b, dpo_b});
    end
    checks++;
    if ({spo_d, dpo_d} !== 4'h0) begin
      errors++; $display("FAIL reset_regs_d got %h exp 0", {spo_d, dpo_d});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear_ab();
    int n = 0;
    ab_clr = 1; ab_we = 1; ab_waddr = 7'd3; ab_wdata = 8'hFF;
    tick();
    ab_clr = 0; ab_we = 0;
    while ((busy_a || busy_b) && n < 300) begin
      checks++;
      if (busy_a !== busy_b) begin
        errors++; $display("FAIL clear_ab_busy_pair got a=%b b=%b exp equal", busy_a, busy_b);
      end
      n++;
      tick();
    end
    checks++;
    if (n != 128) begin
      errors++; $display("FAIL clear_ab_len got %0d exp 128", n);
    end
    for (int r = 0; r < 128; r++) begin
      ab_raddr = 7'(r);
      #1;
      checks++;
      if (dpo_a !== CLR_AB) begin
        errors++; $display("FAIL clear_ab_dpo_a[%0d] got %h exp %h", r, dpo_a, CLR_AB);
      end
      tick();
      checks++;
      if (dpo_b !== CLR_AB) begin
        errors++; $display("FAIL clear_ab_dpo_b[%0d] got %h exp %h", r, dpo_b, CLR_AB);
      end
    end
  endtask

  task automatic test_random_ab();
    logic [7:0] pre_s, pre_d;
    for (int i = 0; i < 10000; i++) begin
      ab_we    = 1'($urandom_range(0, 1));
      ab_waddr = 7'($urandom);
      ab_raddr = 7'($urandom);
      ab_wdata = 8'($urandom);
      ab_clr   = ($urandom_range(0, 299) == 0);
      pre_s = mdl[ab_waddr];
      pre_d = mdl[ab_raddr];
      @(negedge clk);
      checks++;
      if (spo_a !== mdl[ab_waddr]) begin
        errors++; $display("FAIL rand_spo_a cyc %0d got %h exp %h", i, spo_a, mdl[ab_waddr]);
      end
      checks++;
      if (dpo_a !== mdl[ab_raddr]) begin
        errors++; $display("FAIL rand_dpo_a cyc %0d got %h exp %h", i, dpo_a, mdl[ab_raddr]);
      end
      checks++;
      if (busy_a !== (clr_left > 0) || busy_b !== (clr_left > 0)) begin
        errors++; $display("FAIL rand_busy cyc %0d got a=%b b=%b exp %b", i, busy_a, busy_b, clr_left > 0);
      end
      tick();
      checks++;
      if (spo_b !== pre_s) begin
        errors++; $display("FAIL rand_spo_b cyc %0d got %h exp %h", i, spo_b, pre_s);
      end
      checks++;
      if (dpo_b !== pre_d) begin
        errors++; $display("FAIL rand_dpo_b cyc %0d got %h exp %h", i, dpo_b, pre_d);
      end
    end
    ab_we = 0; ab_clr = 0;
  endtask

  task automatic test_write_read_c();
    cd_we = 1; cd_waddr = 6'd5; cd_wdata = 2'b10; cd_raddr = 6'd5;
    tick();
    cd_we = 0;
    checks++;
    if (dpo_c !== 2'b10) begin
      errors++; $display("FAIL wr_dpo_c got %b exp 10", dpo_c);
    end
    checks++;
    if (spo_c !== 2'b10) begin
      errors++; $display("FAIL wr_spo_c got %b exp 10", spo_c);
    end
  endtask

  task automatic test_read_first_d();
    cd_we = 1; cd_waddr = 6'd7; cd_wdata = 2'b10; cd_raddr = 6'd7;
    tick();
    cd_wdata = 2'b01;
    tick();
    cd_we = 0;
    checks++;
    if (dpo_d !== 2'b10) begin
      errors++; $display("FAIL rf_dpo_d_old got %b exp 10", dpo_d);
    end
    checks++;
    if (dpo_c !== 2'b01) begin
      errors++; $display("FAIL rf_dpo_c_new got %b exp 01", dpo_c);
    end
    tick();
    checks++;
    if (dpo_d !== 2'b01 || spo_d !== 2'b01) begin
      errors++; $display("FAIL rf_d_new got dpo=%b spo=%b exp 01", dpo_d, spo_d);
    end
  endtask

  task automatic test_clear_cd();
    int n_c = 0;
    int n_d = 0;
    cd_clr = 1; cd_we = 1; cd_waddr = 6'd4; cd_wdata = 2'b01;
    tick();
    for (int k = 0; k < 200; k++) begin
      if (!busy_d) break;
      if (busy_c) n_c++;
      n_d++;
      if (busy_c) begin
        cd_we = 1; cd_waddr = 6'($urandom); cd_wdata = 2'b00; cd_clr = 1'($urandom_range(0, 1));
      end else begin
        cd_we = 0; cd_clr = 0;
      end
      tick();
    end
    cd_we = 0; cd_clr = 0;
    checks++;
    if (n_c != 32) begin
      errors++; $display("FAIL clear_c_len got %0d exp 32", n_c);
    end
    checks++;
    if (n_d != 64) begin
      errors++; $display("FAIL clear_d_len got %0d exp 64", n_d);
    end
    for (int r = 0; r < 64; r++) begin
      cd_raddr = 6'(r);
      #1;
      if (r < 32) begin
        checks++;
        if (dpo_c !== CLR_CD) begin
          errors++; $display("FAIL clear_c_word[%0d] got %b exp %b", r, dpo_c, CLR_CD);
        end
      end
      tick();
      checks++;
      if (dpo_d !== CLR_CD) begin
        errors++; $display("FAIL clear_d_word[%0d] got %b exp %b", r, dpo_d, CLR_CD);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [1:0] exp_w;
    for (int a = 0; a < 32; a++) begin
      cd_we = 1; cd_waddr = 6'(a); cd_wdata = 2'b10;
      tick();
    end
    cd_we = 0; cd_clr = 1;
    tick();
    cd_clr = 0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_c !== 1'b0 || busy_d !== 1'b0) begin
      errors++; $display("FAIL abort_busy got c=%b d=%b exp 0", busy_c, busy_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cd_we = 1; cd_waddr = 6'd31; cd_wdata = 2'b01;
    tick();
    cd_we = 0;
    for (int r = 0; r < 32; r++) begin
      cd_raddr = 6'(r);
      #1;
      exp_w = (r == 31) ? 2'b01 : (r < 10) ? CLR_CD : 2'b10;
      checks++;
      if (dpo_c !== exp_w) begin
        errors++; $display("FAIL abort_word[%0d] got %b exp %b", r, dpo_c, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_ab();
    test_random_ab();
    test_write_read_c();
    test_read_first_d();
    test_clear_cd();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
